// File: rtl/inst_decode_pkg.sv
// Shared RV32 decode definitions: format codes, opcode constants, decoded-field
// record and the opcode-to-format classifier used by decoder and execute blocks.
package inst_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_st_e;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    logic       illegal;
  } dec_fields_t;

  // Compressed encodings (low bits != 11) are not supported and decode as ILL.
  function automatic fmt_e opcode_fmt(input logic [31:0] inst);
    fmt_e f;
    if (inst[1:0] != 2'b11) begin
      f = FMT_ILL;
    end else begin
      case (inst[6:0])
        OP_OP:                                f = FMT_R;
        OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:  f = FMT_I;
        OP_STORE:                             f = FMT_S;
        OP_BRANCH:                            f = FMT_B;
        OP_LUI, OP_AUIPC:                     f = FMT_U;
        OP_JAL:                               f = FMT_J;
        default:                              f = FMT_ILL;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/inst_field_extract.sv
// Purely combinational RV32 field and immediate extraction; the immediate is
// sign-extended from instruction bit 31 to XLEN.
module inst_field_extract
  import inst_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output dec_fields_t     o_fields,
  output logic [XLEN-1:0] o_imm
);

  fmt_e        w_fmt;
  logic [31:0] w_imm32;

  assign w_fmt = opcode_fmt(i_inst);

  always_comb begin
    o_fields.fmt     = w_fmt;
    o_fields.opcode  = i_inst[6:0];
    o_fields.rd      = i_inst[11:7];
    o_fields.funct3  = i_inst[14:12];
    o_fields.rs1     = i_inst[19:15];
    o_fields.rs2     = i_inst[24:20];
    o_fields.funct7  = i_inst[31:25];
    o_fields.illegal = (w_fmt == FMT_ILL);
  end

  // R and ILL carry no immediate.
  always_comb begin
    w_imm32 = 32'd0;
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      FMT_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      FMT_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                          i_inst[11:8], 1'b0};
      FMT_U:   w_imm32 = {i_inst[31:12], 12'd0};
      FMT_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                          i_inst[30:21], 1'b0};
      default: w_imm32 = 32'd0;
    endcase
  end

  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/inst_decode_stage.sv
// Decode pipeline stage: one output register plus one skid entry behind a
// valid/ready handshake, with saturating decoded/illegal event counters.
module inst_decode_stage
  import inst_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       fmt,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [CNT_W-1:0] ill_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dec_fields_t      w_dec;
  logic [XLEN-1:0]  w_dec_imm;
  logic             w_acc;
  logic             w_drain;

  stage_st_e        r_state;
  dec_fields_t      r_out;
  dec_fields_t      r_skid;
  logic [XLEN-1:0]  r_out_imm;
  logic [XLEN-1:0]  r_skid_imm;
  logic             r_out_valid;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_dec_cnt;
  logic [CNT_W-1:0] r_ill_cnt;

  inst_field_extract #(.XLEN(XLEN)) u_extract (
    .i_inst   (instruction_word),
    .o_fields (w_dec),
    .o_imm    (w_dec_imm)
  );

  assign w_acc   = in_valid & r_in_ready;
  assign w_drain = r_out_valid & out_ready;

  // in_ready is a register that only drops on entry to TWO, so out_ready
  // never reaches it combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out       <= '0;
      r_skid      <= '0;
      r_out_imm   <= '0;
      r_skid_imm  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_out       <= w_dec;
            r_out_imm   <= w_dec_imm;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drain) begin
            r_out     <= w_dec;
            r_out_imm <= w_dec_imm;
          end else if (w_acc) begin
            r_skid     <= w_dec;
            r_skid_imm <= w_dec_imm;
            r_in_ready <= 1'b0;
            r_state    <= ST_TWO;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_drain) begin
            r_out      <= r_skid;
            r_out_imm  <= r_skid_imm;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_EMPTY;
        end
      endcase
    end
  end

  // Event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_cnt <= '0;
      r_ill_cnt <= '0;
    end else if (w_acc) begin
      if (r_dec_cnt != CNT_MAX) begin
        r_dec_cnt <= r_dec_cnt + CNT_W'(1);
      end
      if (w_dec.illegal && (r_ill_cnt != CNT_MAX)) begin
        r_ill_cnt <= r_ill_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign fmt       = r_out.fmt;
  assign opcode    = r_out.opcode;
  assign rd        = r_out.rd;
  assign funct3    = r_out.funct3;
  assign rs1       = r_out.rs1;
  assign rs2       = r_out.rs2;
  assign funct7    = r_out.funct7;
  assign illegal   = r_out.illegal;
  assign imm       = r_out_imm;
  assign dec_cnt   = r_dec_cnt;
  assign ill_cnt   = r_ill_cnt;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Randomized scoreboard bench for inst_decode_stage with a reference decoder
// computed from the RV32 immediate rules using plain integer arithmetic.
module tb_inst_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction_word;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [6:0]       funct7;
  logic [XLEN-1:0]  imm;
  logic             illegal;
  logic [CNT_W-1:0] dec_cnt;
  logic [CNT_W-1:0] ill_cnt;

  inst_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .fmt              (fmt),
    .opcode           (opcode),
    .rd               (rd),
    .funct3           (funct3),
    .rs1              (rs1),
    .rs2              (rs2),
    .funct7           (funct7),
    .imm              (imm),
    .illegal          (illegal),
    .dec_cnt          (dec_cnt),
    .ill_cnt          (ill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] fmt;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    logic       illegal;
    longint     imm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   pend = 0;
  int   pend_ill = 0;
  int   acc_dec = 0;
  int   acc_ill = 0;
  bit   mon_en = 1'b0;

  int              mon_held;
  exp_t            mon_e;
  logic [63:0]     mon_imm64;
  logic [XLEN-1:0] mon_imm;

  logic [6:0] legal_ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                 7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111,
                                 7'b0010111, 7'b1101111};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t   e;
    longint v;
    e.opcode = w[6:0];
    e.rd     = w[11:7];
    e.funct3 = w[14:12];
    e.rs1    = w[19:15];
    e.rs2    = w[24:20];
    e.funct7 = w[31:25];
    e.fmt    = 3'd7;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'b0110011:                                     e.fmt = 3'd0;
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: e.fmt = 3'd1;
        7'b0100011:                                     e.fmt = 3'd2;
        7'b1100011:                                     e.fmt = 3'd3;
        7'b0110111, 7'b0010111:                         e.fmt = 3'd4;
        7'b1101111:                                     e.fmt = 3'd5;
        default:                                        e.fmt = 3'd7;
      endcase
    end
    v = 0;
    case (e.fmt)
      3'd1: v = longint'(w[31:20]) - (w[31] ? 64'sd4096 : 64'sd0);
      3'd2: v = longint'(w[31:25]) * 32 + longint'(w[11:7]) - (w[31] ? 64'sd4096 : 64'sd0);
      3'd3: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
                - (w[31] ? 64'sd4096 : 64'sd0);
      3'd4: v = longint'(w[31:12]) * 4096 - (w[31] ? 64'sd4294967296 : 64'sd0);
      3'd5: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
                - (w[31] ? 64'sd1048576 : 64'sd0);
      default: v = 0;
    endcase
    e.imm     = v;
    e.illegal = (e.fmt == 3'd7);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int          sel;
    w   = $urandom;
    sel = $urandom_range(0, 12);
    if (sel < 10) begin
      w[6:0] = legal_ops[sel];
    end else if (sel == 10) begin
      w[1:0] = 2'($urandom_range(0, 2));
    end else if (sel == 11) begin
      w = 32'h0000_0000;
    end
    return w;
  endfunction

  // Drive one cycle of stimulus just after the edge; queue the expectation if
  // the upcoming edge will transfer it.
  task automatic step(input logic v, input logic [31:0] w, input logic ordy);
    exp_t e;
    @(posedge clk);
    #1;
    if (pend != 0) begin
      if (acc_dec < CMAX) acc_dec++;
      if (pend_ill != 0 && acc_ill < CMAX) acc_ill++;
    end
    pend             = 0;
    pend_ill         = 0;
    in_valid         = v;
    instruction_word = w;
    out_ready        = ordy;
    if (v && in_ready) begin
      e = ref_decode(w);
      q.push_back(e);
      pend     = 1;
      pend_ill = e.illegal ? 1 : 0;
    end
  endtask

  // Offer one instruction until taken, bounded.
  task automatic offer(input logic [31:0] w, input logic ordy);
    int tries;
    tries = 0;
    do begin
      step(1'b1, w, ordy);
      tries++;
    end while (pend == 0 && tries < 20);
    check("offer_accepted", pend, 1);
  endtask

  // Scoreboard monitor: every presented output must match the oldest held expectation.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      mon_held = q.size() - pend;
      check("in_ready", in_ready, (mon_held < 2) ? 1 : 0);
      check("out_valid", out_valid, (mon_held > 0) ? 1 : 0);
      check("dec_cnt", dec_cnt, acc_dec);
      check("ill_cnt", ill_cnt, acc_ill);
      if (out_valid && mon_held > 0) begin
        mon_e     = q[0];
        mon_imm64 = mon_e.imm;
        mon_imm   = mon_imm64[XLEN-1:0];
        check("fmt", fmt, mon_e.fmt);
        check("opcode", opcode, mon_e.opcode);
        check("rd", rd, mon_e.rd);
        check("funct3", funct3, mon_e.funct3);
        check("rs1", rs1, mon_e.rs1);
        check("rs2", rs2, mon_e.rs2);
        check("funct7", funct7, mon_e.funct7);
        check("illegal", illegal, mon_e.illegal);
        check("imm", imm, mon_imm);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instruction_word = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_imm", imm, 0);
    check("rst_fmt", fmt, 0);
    check("rst_rd", rd, 0);
    check("rst_cnt", {dec_cnt, ill_cnt}, 0);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Two S-type stores with known immediates.
    step(1'b1, 32'h0E06_AEA3, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    #1;
    check("s1_fmt", fmt, 2);
    check("s1_rs1", rs1, 13);
    check("s1_imm", imm, 32'h0000_00FD);
    step(1'b1, 32'h88B3_A0A3, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    #1;
    check("s2_rs2", rs2, 11);
    check("s2_rs1", rs1, 7);
    check("s2_imm", imm, 32'hFFFF_F881);

    // Back-to-back I then U with no bubble.
    step(1'b1, 32'hFFF0_0093, 1'b1);
    step(1'b1, 32'h1234_50B7, 1'b1);
    #1;
    check("i_imm", imm, 32'hFFFF_FFFF);
    check("i_fmt", fmt, 1);
    step(1'b0, 32'h0, 1'b1);
    #1;
    check("u_imm", imm, 32'h1234_5000);
    check("u_rd", rd, 1);

    // All-zero word is illegal.
    step(1'b1, 32'h0000_0000, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    #1;
    check("ill_fmt", fmt, 7);
    check("ill_flag", illegal, 1);
    check("ill_imm", imm, 0);
    step(1'b0, 32'h0, 1'b1);

    // Backpressure: two accepted, third waits for drain.
    step(1'b1, 32'h0020_8133, 1'b0);
    step(1'b1, 32'h0041_2183, 1'b0);
    step(1'b1, 32'h0000_006F, 1'b0);
    check("bp_third_rejected", pend, 0);
    repeat (3) step(1'b1, 32'h0000_006F, 1'b0);
    offer(32'h0000_006F, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // Randomized traffic, including enough ILL words to saturate ill_cnt.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_inst(), 1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);
    check("drain_empty", q.size(), 0);

    // Reset while holding two instructions.
    step(1'b1, 32'h0010_0093, 1'b0);
    step(1'b1, 32'h0020_0113, 1'b0);
    step(1'b1, 32'h0030_0193, 1'b0);
    check("two_in_ready", in_ready, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_cnt", {dec_cnt, ill_cnt}, 0);
    q.delete();
    pend = 0; pend_ill = 0; acc_dec = 0; acc_ill = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_0013, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    check("end_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
INST_DECODE_STAGE -- requirements
Module: inst_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of immediate output; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 16, width of the decoded and illegal event counters.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  instruction_word is valid this cycle.
REQ-006 Port in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 Port instruction_word  input  32  raw RV32 instruction.
REQ-008 Port out_valid  output  1  decoded fields valid.
REQ-009 Port out_ready  input  1  downstream accepts decoded fields.
REQ-010 Port fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-011 Ports opcode 7, rd 5, funct3 3, rs1 5, rs2 5, funct7 7  outputs  raw fields of the held instruction.
REQ-012 Port imm  output  XLEN  sign-extended immediate; 0 for R and ILL.
REQ-013 Port illegal  output  1  held instruction is not a supported encoding.
REQ-014 Ports dec_cnt, ill_cnt  outputs  CNT_W  accepted-instruction and illegal-instruction counts.

Function
REQ-015 Transfer occurs on a side when valid and ready are both 1 at a rising clk edge.
REQ-016 Latency SHALL be one cycle: an instruction accepted at edge N is presented on the outputs with out_valid=1 after edge N when the output register is empty or draining.
REQ-017 Storage SHALL be one output register plus one skid entry; full throughput (one transfer per cycle) SHALL be sustained while out_ready=1.
REQ-018 in_ready SHALL be registered and equal to NOT skid_full; no combinational path from out_ready to in_ready.
REQ-019 States: EMPTY (out_valid=0), ONE (out reg full, skid empty), TWO (both full); EMPTY->ONE on accept; ONE->ONE on accept+drain; ONE->TWO on accept without drain; TWO->ONE on drain (skid moves to out reg); ONE->EMPTY on drain without accept.
REQ-020 Order SHALL be preserved; no instruction is dropped or duplicated; in TWO, in_ready=0 and in_valid is ignored.
REQ-021 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 Format by opcode: 0110011 R; 0010011, 0000011, 1100111, 1110011 I; 0100011 S; 1100011 B; 0110111, 0010111 U; 1101111 J; any other opcode, or instruction_word[1:0] != 2'b11, ILL with illegal=1.
REQ-023 Immediates before sign extension from bit 31: I inst[31:20]; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-024 Decode SHALL be performed on input before registering; registered outputs carry no combinational logic to ports.
REQ-025 dec_cnt SHALL increment on each input transfer; ill_cnt on each input transfer decoded ILL; both saturate at all-ones.

Reset
REQ-026 While rst=1: out_valid=0, in_ready=1 (asserted one cycle after rst falls is NOT required -- it is 1 during and after reset), state EMPTY, all field outputs, imm, illegal, dec_cnt, ill_cnt = 0.
REQ-027 Reset asserted mid-operation SHALL discard both held instructions immediately, without waiting for a clock edge.

Structure
REQ-028 Format codes, opcode constants and the ILL encoding SHALL live in a shared package used by all decoder and execute blocks.
REQ-029 Combinational field/immediate extraction SHALL be a sub-module inst_field_extract (parameter XLEN); inst_decode_stage holds the handshake, skid and counters.

Verification
REQ-030 S-type 0000111_00000_01101_010_11101_0100011, out_ready=1 -> next cycle fmt=S, rs1=13, rs2=0, funct3=2, imm=0x0000_00FD, illegal=0.
REQ-031 S-type 1000100_01011_00111_010_00001_0100011 -> rs2=11, rs1=7, imm=0xFFFF_F881 (XLEN=64: 0xFFFF_FFFF_FFFF_F881).
REQ-032 32'hFFF0_0093 then 32'h1234_50B7 back-to-back -> I, rd=1, imm=0xFFFF_FFFF; then U, rd=1, imm=0x1234_5000; no bubble.
REQ-033 out_ready=0 with three instructions offered -> two accepted, in_ready=0 after second, outputs stable; out_ready=1 -> delivered in order, third accepted.
REQ-034 32'h0000_0000 accepted -> fmt=ILL, illegal=1, imm=0, ill_cnt=1, dec_cnt=1.
REQ-035 rst pulsed while state TWO -> out_valid=0 and counters=0 immediately; nothing of the held instructions appears after reset.
